// File: rtl/fx2_bus_scheduler.sv
// FX2 slave-FIFO bus owner: round-robin time-sharing of the FD bus between OUT-EP reads and IN-EP writes.
// Optional FX2_PKTEND_EN: a written word flagged tx_last is followed by a one-cycle PKTEND commit.
module fx2_bus_scheduler #(
    parameter logic [1:0] RD_EP_ADDR  = 2'b00,
    parameter logic [1:0] WR_EP_ADDR  = 2'b10,
    parameter int         TURN_CYCLES = 2,
    parameter int         MAX_BURST   = 16,
    parameter int         DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fx2_flaga,
    input  logic              fx2_flagd,
    output logic              fx2_slcs_n,
    output logic              fx2_slrd_n,
    output logic              fx2_slwr_n,
    output logic              fx2_sloe_n,
    output logic              fx2_pktend_n,
    output logic [1:0]        fx2_a,
    input  logic [DATA_W-1:0] fx2_db_in,
    output logic [DATA_W-1:0] fx2_db_out,
    output logic              fx2_db_oe,
    input  logic              rx_ready,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic [1:0]        grant
);

    localparam int TW = $clog2(TURN_CYCLES + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_TURN,
        S_RD_REC,
        S_RD_STB,
        S_WR_TURN,
        S_WR_REC,
        S_WR_CAP,
        S_WR_STB,
        S_PKTEND
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] turn_cnt, turn_nxt;
    logic [BW-1:0] burst_cnt, burst_nxt;
    logic          last_wr, last_wr_nxt;
    logic          rd_ok, wr_ok, word_last;
    logic          slcs_n_nxt, slrd_n_nxt, slwr_n_nxt, sloe_n_nxt, pktend_n_nxt;
    logic          db_oe_nxt, tx_ready_nxt;
    logic [1:0]    a_nxt, grant_nxt;

    assign rd_ok = fx2_flaga & rx_ready;
    assign wr_ok = fx2_flagd & tx_valid;

`ifdef FX2_PKTEND_EN
    logic last_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_q <= 1'b0;
        else if (state == S_WR_CAP)
            last_q <= tx_last;
    end
    assign word_last = last_q;
`else
    logic tx_last_unused;
    assign tx_last_unused = tx_last;
    assign word_last      = 1'b0;
`endif

    // Outputs are decoded from the next state so every pin is a plain flop.
    always_comb begin
        state_nxt    = state;
        turn_nxt     = turn_cnt;
        burst_nxt    = burst_cnt;
        last_wr_nxt  = last_wr;
        slcs_n_nxt   = 1'b1;
        slrd_n_nxt   = 1'b1;
        slwr_n_nxt   = 1'b1;
        sloe_n_nxt   = 1'b1;
        pktend_n_nxt = 1'b1;
        db_oe_nxt    = 1'b0;
        tx_ready_nxt = 1'b0;
        a_nxt        = fx2_a;
        grant_nxt    = 2'b00;

        case (state)
            S_IDLE: begin
                turn_nxt  = '0;
                burst_nxt = '0;
                if (rd_ok && (!wr_ok || last_wr)) begin
                    state_nxt   = S_RD_TURN;
                    last_wr_nxt = 1'b0;
                end else if (wr_ok) begin
                    state_nxt   = S_WR_TURN;
                    last_wr_nxt = 1'b1;
                end
            end
            S_RD_TURN, S_WR_TURN: begin
                if (turn_cnt == TURN_LAST)
                    state_nxt = (state == S_RD_TURN) ? S_RD_REC : S_WR_REC;
                else
                    turn_nxt = turn_cnt + 1'b1;
            end
            S_RD_REC: state_nxt = (burst_cnt == BURST_MAX || !rd_ok) ? S_IDLE : S_RD_STB;
            S_RD_STB: begin
                state_nxt = S_RD_REC;
                burst_nxt = burst_cnt + 1'b1;
            end
            S_WR_REC: state_nxt = (burst_cnt == BURST_MAX || !wr_ok) ? S_IDLE : S_WR_CAP;
            S_WR_CAP: state_nxt = S_WR_STB;
            S_WR_STB: begin
                state_nxt = word_last ? S_PKTEND : S_WR_REC;
                burst_nxt = burst_cnt + 1'b1;
            end
            S_PKTEND: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase

        case (state_nxt)
            S_RD_TURN, S_RD_REC, S_RD_STB: begin
                slcs_n_nxt = 1'b0;
                a_nxt      = RD_EP_ADDR;
                grant_nxt  = 2'b01;
                // FX2 needs SLOE low one cycle before the first read strobe
                sloe_n_nxt = (state_nxt == S_RD_TURN) ? (turn_nxt != TURN_LAST) : 1'b0;
                slrd_n_nxt = (state_nxt != S_RD_STB);
            end
            S_WR_TURN, S_WR_REC, S_WR_CAP, S_WR_STB, S_PKTEND: begin
                slcs_n_nxt   = 1'b0;
                a_nxt        = WR_EP_ADDR;
                grant_nxt    = 2'b10;
                tx_ready_nxt = (state_nxt == S_WR_CAP);
                slwr_n_nxt   = (state_nxt != S_WR_STB);
                db_oe_nxt    = (state_nxt == S_WR_STB);
                pktend_n_nxt = (state_nxt != S_PKTEND);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            turn_cnt     <= '0;
            burst_cnt    <= '0;
            last_wr      <= 1'b1;
            fx2_slcs_n   <= 1'b1;
            fx2_slrd_n   <= 1'b1;
            fx2_slwr_n   <= 1'b1;
            fx2_sloe_n   <= 1'b1;
            fx2_pktend_n <= 1'b1;
            fx2_a        <= RD_EP_ADDR;
            fx2_db_out   <= '0;
            fx2_db_oe    <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            tx_ready     <= 1'b0;
            grant        <= 2'b00;
        end else begin
            state        <= state_nxt;
            turn_cnt     <= turn_nxt;
            burst_cnt    <= burst_nxt;
            last_wr      <= last_wr_nxt;
            fx2_slcs_n   <= slcs_n_nxt;
            fx2_slrd_n   <= slrd_n_nxt;
            fx2_slwr_n   <= slwr_n_nxt;
            fx2_sloe_n   <= sloe_n_nxt;
            fx2_pktend_n <= pktend_n_nxt;
            fx2_a        <= a_nxt;
            fx2_db_oe    <= db_oe_nxt;
            tx_ready     <= tx_ready_nxt;
            grant        <= grant_nxt;
            rx_valid     <= (state == S_RD_STB);
            if (state == S_RD_STB)
                rx_data <= fx2_db_in;
            if (state == S_WR_CAP)
                fx2_db_out <= tx_data;
        end
    end

endmodule

// File: tb/tb_fx2_bus_scheduler.sv
// Directed bench for fx2_bus_scheduler: FX2 FIFO and producer models driven on the falling edge.
module tb_fx2_bus_scheduler;

    localparam int TURN = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fx2_flaga, fx2_flagd;
    logic        fx2_slcs_n, fx2_slrd_n, fx2_slwr_n, fx2_sloe_n, fx2_pktend_n;
    logic [1:0]  fx2_a;
    logic [15:0] fx2_db_in, fx2_db_out;
    logic        fx2_db_oe;
    logic        rx_ready, rx_valid;
    logic [15:0] rx_data;
    logic        tx_valid, tx_last, tx_ready;
    logic [15:0] tx_data;
    logic [1:0]  grant;

    always #5 clk = ~clk;

    fx2_bus_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .fx2_flaga(fx2_flaga), .fx2_flagd(fx2_flagd),
        .fx2_slcs_n(fx2_slcs_n), .fx2_slrd_n(fx2_slrd_n), .fx2_slwr_n(fx2_slwr_n),
        .fx2_sloe_n(fx2_sloe_n), .fx2_pktend_n(fx2_pktend_n), .fx2_a(fx2_a),
        .fx2_db_in(fx2_db_in), .fx2_db_out(fx2_db_out), .fx2_db_oe(fx2_db_oe),
        .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
        .grant(grant)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // OUT FIFO and write-producer models
    logic [15:0] rd_mem [0:127];
    logic [15:0] tx_mem [0:127];
    logic        tx_lm  [0:127];
    int rd_cnt = 0, rd_idx = 0, tx_cnt = 0, tx_idx = 0;
    bit rd_pend = 0, tx_pend = 0;

    assign fx2_flaga = (rd_idx < rd_cnt);
    assign fx2_db_in = rd_mem[rd_idx[6:0]];
    assign tx_valid  = (tx_idx < tx_cnt);
    assign tx_data   = tx_mem[tx_idx[6:0]];
    assign tx_last   = tx_lm[tx_idx[6:0]];

    // Observation state
    int cyc = 0, rx_n = 0, wr_n = 0, pk_n = 0, pk_cyc = 0, viol = 0, g_n = 0;
    int quiet = 0, min_quiet = 1000, n_switch = 0;
    bit have_side = 0, last_side = 0, side = 0;
    logic [1:0] prev_grant = 2'b00, pk_a = 2'b00;
    logic [15:0] rx_buf [0:63];
    logic [15:0] wr_buf [0:63];
    int rx_cyc [0:63];
    int wr_cyc [0:63];
    logic [1:0] g_log [0:15];

    always @(negedge clk) begin
        cyc++;
        if (rd_pend) rd_idx++;
        rd_pend = !fx2_slrd_n;
        if (tx_pend) tx_idx++;
        tx_pend = tx_ready;
        if (rx_valid) begin
            if (rx_n < 64) begin rx_buf[rx_n] = rx_data; rx_cyc[rx_n] = cyc; end
            rx_n++;
        end
        if (!fx2_slwr_n) begin
            if (wr_n < 64) begin wr_buf[wr_n] = fx2_db_out; wr_cyc[wr_n] = cyc; end
            wr_n++;
        end
        if (!fx2_pktend_n) begin pk_n++; pk_cyc = cyc; pk_a = fx2_a; end
        if ((!fx2_sloe_n && fx2_db_oe) || (!fx2_slrd_n && !fx2_slwr_n)) viol++;
        // Bus-quiet cycles between the last read-side and the first write-side bus activity
        if (!fx2_sloe_n || fx2_db_oe) begin
            side = fx2_db_oe;
            if (have_side && side != last_side) begin
                n_switch++;
                if (quiet < min_quiet) min_quiet = quiet;
            end
            have_side = 1; last_side = side; quiet = 0;
        end else begin
            quiet++;
        end
        if (grant != prev_grant && grant != 2'b00) begin
            if (g_n < 16) g_log[g_n] = grant;
            g_n++;
        end
        prev_grant = grant;
    end

    task automatic check_reset_outputs(input string p);
        check_eq({p, "_strobes"}, {fx2_slcs_n, fx2_slrd_n, fx2_slwr_n, fx2_sloe_n, fx2_pktend_n}, 5'b11111);
        check_eq({p, "_fx2_a"}, fx2_a, 2'b00);
        check_eq({p, "_db_out"}, fx2_db_out, 16'h0000);
        check_eq({p, "_db_oe"}, fx2_db_oe, 1'b0);
        check_eq({p, "_rx_valid"}, rx_valid, 1'b0);
        check_eq({p, "_rx_data"}, rx_data, 16'h0000);
        check_eq({p, "_tx_ready"}, tx_ready, 1'b0);
        check_eq({p, "_grant"}, grant, 2'b00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; fx2_flagd = 1'b0; rx_ready = 1'b0; rd_cnt = 0; tx_cnt = 0;
        repeat (2) @(negedge clk);
        #1;
        rd_idx = 0; rd_pend = 0; tx_idx = 0; tx_pend = 0;
        rx_n = 0; wr_n = 0; pk_n = 0; pk_cyc = 0; viol = 0; g_n = 0; prev_grant = 2'b00;
        have_side = 0; quiet = 0; min_quiet = 1000; n_switch = 0;
        rst_n = 1'b1;
    endtask

    task automatic load_rd(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) rd_mem[i] = base + 16'(i);
        rd_cnt = n;
    endtask

    task automatic load_tx(input int n, input logic [15:0] base, input int last_at);
        for (int i = 0; i < 128; i++) begin
            tx_mem[i] = base + 16'(i);
            tx_lm[i]  = (i == last_at);
        end
        tx_cnt = n;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int bad;
        fx2_flagd = 1'b0; rx_ready = 1'b0;
        for (int i = 0; i < 128; i++) begin rd_mem[i] = '0; tx_mem[i] = '0; tx_lm[i] = 1'b0; end
        step(2);
        check_reset_outputs("por");

        // Single write: tx_ready, then strobe with the captured word on the next cycle
        do_reset();
        load_tx(1, 16'hA5A5, -1);
        fx2_flagd = 1'b1;
        for (int i = 0; i < 30 && tx_ready !== 1'b1; i++) step(1);
        check_eq("wr_tx_ready", tx_ready, 1'b1);
        check_eq("wr_no_strobe_in_cap", fx2_slwr_n, 1'b1);
        step(1);
        check_eq("wr_slwr_n", fx2_slwr_n, 1'b0);
        check_eq("wr_db_out", fx2_db_out, 16'hA5A5);
        check_eq("wr_db_oe", fx2_db_oe, 1'b1);
        check_eq("wr_sloe_n", fx2_sloe_n, 1'b1);
        check_eq("wr_fx2_a", fx2_a, 2'b10);
        check_eq("wr_tx_ready_pulse", tx_ready, 1'b0);
        step(8);
        check_eq("wr_count", wr_n, 1);
        check_eq("wr_grant_idle", grant, 2'b00);

        // Read burst: 16 words in the first grant, remaining 4 after IDLE + turnaround
        do_reset();
        load_rd(20, 16'h0001);
        rx_ready = 1'b1;
        for (int i = 0; i < 300 && rx_n < 20; i++) step(1);
        step(10);
        check_eq("rd_count", rx_n, 20);
        bad = 0;
        for (int i = 0; i < 20; i++) if (rx_buf[i] !== 16'(i + 1)) bad++;
        check_eq("rd_order", bad, 0);
        check_eq("rd_burst_spacing", rx_cyc[15] - rx_cyc[0], 30);
        check_eq("rd_regrant_gap", rx_cyc[16] - rx_cyc[15], 4 + TURN);
        check_eq("rd_grants", g_n, 2);
        check_eq("rd_grant_kind", {g_log[0], g_log[1]}, 4'b0101);

        // Contention: both sides eligible, grants alternate RD,WR,RD,WR,RD,WR
        do_reset();
        load_rd(40, 16'h0100);
        load_tx(40, 16'h0200, -1);
        rx_ready = 1'b1; fx2_flagd = 1'b1;
        for (int i = 0; i < 2000 && (rx_n < 40 || wr_n < 40); i++) step(1);
        step(10);
        check_eq("ct_rx_count", rx_n, 40);
        check_eq("ct_wr_count", wr_n, 40);
        check_eq("ct_grant_seq", {g_log[0], g_log[1], g_log[2], g_log[3]}, 8'b01100110);
        check_eq("ct_grants", g_n, 6);
        check_eq("ct_switches", n_switch, 5);
        check_eq("ct_switch_gap_ge_turn", (min_quiet >= TURN), 1'b1);
        check_eq("ct_invariant", viol, 0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (rx_buf[i] !== 16'h0100 + 16'(i)) bad++;
            if (wr_buf[i] !== 16'h0200 + 16'(i)) bad++;
        end
        check_eq("ct_order", bad, 0);

        // Backpressure: flagd low for 5 cycles after the third word
        do_reset();
        load_tx(6, 16'h000D, -1);
        fx2_flagd = 1'b1;
        for (int i = 0; i < 100 && wr_n < 3; i++) step(1);
        check_eq("bp_first3", wr_n, 3);
        fx2_flagd = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (tx_ready || !fx2_slwr_n) bad++;
        end
        check_eq("bp_stalled", bad, 0);
        fx2_flagd = 1'b1;
        for (int i = 0; i < 100 && wr_n < 6; i++) step(1);
        step(10);
        check_eq("bp_count", wr_n, 6);
        bad = 0;
        for (int i = 0; i < 6; i++) if (wr_buf[i] !== 16'h000D + 16'(i)) bad++;
        check_eq("bp_order", bad, 0);
        check_eq("bp_grants", g_n, 2);
        check_eq("bp_invariant", viol, 0);

        // tx_last on the third word
        do_reset();
        load_tx(5, 16'h0301, 2);
        fx2_flagd = 1'b1;
        for (int i = 0; i < 200 && wr_n < 5; i++) step(1);
        step(10);
        check_eq("pk_count", wr_n, 5);
        bad = 0;
        for (int i = 0; i < 5; i++) if (wr_buf[i] !== 16'h0301 + 16'(i)) bad++;
        check_eq("pk_order", bad, 0);
`ifdef FX2_PKTEND_EN
        check_eq("pk_pulses", pk_n, 1);
        check_eq("pk_after_third", pk_cyc - wr_cyc[2], 1);
        check_eq("pk_fx2_a", pk_a, 2'b10);
        check_eq("pk_grants", g_n, 2);
`else
        check_eq("pk_pulses", pk_n, 0);
        check_eq("pk_grants", g_n, 1);
`endif

        // Reset asserted in the capture cycle of a write
        do_reset();
        load_tx(8, 16'hB000, -1);
        fx2_flagd = 1'b1;
        for (int i = 0; i < 30 && tx_ready !== 1'b1; i++) step(1);
        check_eq("mid_tx_ready", tx_ready, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        step(3);
        check_eq("mid_no_strobe", wr_n, 0);
        check_eq("mid_slwr_n", fx2_slwr_n, 1'b1);
        rst_n = 1'b1;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
